l15_req_arb: RTL
================

# l15_req_arb

Two-requester arbiter that shares the single L1.5 transducer request port and routes L1.5 responses back to their owners. It sits between two transducer-side masters (requester 0, requester 1) and the `l15` request/response interface. It owns three things: request sequencing under the L1.5 val/ack protocol, per-requester outstanding-request credit, and response demultiplexing by thread ID.

## Interface
Parameters:
- `REQ_W`, 113: packed request payload width (rqtype, nc, size, address, data, …), passed through opaque.
- `MAX_OUT`, 4: maximum outstanding requests per requester (1..15).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req0_val` / `req1_val` in 1: request valid. Held, with payload stable, until the matching `reqN_ack`.
- `req0_data` / `req1_data` in REQ_W: request payload.
- `req0_ack` / `req1_ack` out 1: one-cycle pulse; request accepted by L1.5.
- `transducer_l15_val` out 1: request valid to L1.5.
- `transducer_l15_req` out REQ_W: registered payload of the granted requester.
- `transducer_l15_threadid` out 1: granted requester index.
- `l15_transducer_header_ack` in 1: L1.5 header accepted.
- `l15_transducer_ack` in 1: L1.5 request fully accepted.
- `l15_transducer_val` in 1: response valid.
- `l15_transducer_returntype` in 4: response type.
- `l15_transducer_threadid` in 1: response owner.
- `transducer_l15_req_ack` out 1: response consumed.
- `rsp0_val` / `rsp1_val` out 1: response valid to requester N. Payload is shared from L1.5 outputs.
- `rsp0_rdy` / `rsp1_rdy` in 1: requester N accepts response.
- `err_orphan` out 1: sticky; a solicited response arrived for a requester with zero outstanding.

## Operation
Request FSM states: IDLE, ISSUE, HDR.
- **IDLE.** Requester N is eligible when `reqN_val=1` and `cntN<MAX_OUT`.
  - One eligible requester: grant it.
  - Two eligible: round-robin; grant the one not equal to `last_gnt`.
  - On grant: capture payload into `transducer_l15_req`, set `transducer_l15_threadid=N`, set `last_gnt=N`, go to ISSUE.
- **ISSUE.** Drive `transducer_l15_val=1`.
  - `l15_transducer_ack=1`: pulse `reqN_ack`, increment `cntN`, go to IDLE.
  - Else `header_ack=1`: go to HDR.
- **HDR.** Keep `val=1`; grant is locked. On `ack`: same actions as ISSUE, go to IDLE.

Response routing:
- **Solicited** (returntype ≠ 4'b0011 and ≠ 4'b0111):
  - `rspT_val = l15_transducer_val`, where T = `l15_transducer_threadid`; the other `rsp_val` stays 0.
  - `transducer_l15_req_ack = l15_transducer_val & rspT_rdy`.
  - On handshake: decrement `cntT`. If `cntT=0`, hold at 0 and set `err_orphan`.
- **Unsolicited** (4'b0011 invalidation/evict, 4'b0111 interrupt): broadcast to both requesters.
  - `rspN_val = l15_transducer_val & ~doneN`.
  - `doneN` sets when `rspN_rdy` is accepted alone.
  - `transducer_l15_req_ack` asserts when `(rsp0_rdy|done0) & (rsp1_rdy|done1)`. This also clears both done bits.

Counter rules:
- `cntN` is 4 bits.
- Increment and decrement in the same cycle: value unchanged.
- Increment never exceeds `MAX_OUT`, because grant is blocked at the limit.

Reset:
- `rst` clears FSM to IDLE, `cnt0=cnt1=0`, done bits, and `err_orphan`. Sets `last_gnt=1`, so requester 0 wins the first tie.
- Mid-transaction reset abandons the in-flight request with no ack. L1.5 must be reset in the same cycle.

## Timing
- Reset values:
  - 0: `transducer_l15_val`, `transducer_l15_req`, `transducer_l15_threadid`, `req0_ack`, `req1_ack`, `err_orphan`.
  - `rsp*_val` and `transducer_l15_req_ack` are combinational and are 0 whenever `l15_transducer_val=0`.
- Request path:
  - `req_val` sampled in IDLE at cycle t gives `transducer_l15_val=1` at t+1.
  - With ack at t+1, `reqN_ack` pulses at t+1 and the next grant can be issued at t+2.
  - Back-to-back throughput: one request per 2 cycles minimum.
- `reqN_ack` is combinational from `l15_transducer_ack` in ISSUE/HDR. It is never asserted outside those states.
- Response path is zero-latency combinational. No response buffering.
- A requester that sees `reqN_ack` must drop or change `reqN_val` in the next cycle. Otherwise it is treated as a new request.

## Configuration
- `L15_REQ_ARB_FIXED_PRIO_EN` defined: tie-break is fixed, requester 0 always wins; `last_gnt` is unused.
- Undefined (default): round-robin as above.
- Credit limits and response routing are identical in both builds.

## Test plan
- Single request: `req0_val=1` with payload 0x1234. Expect `transducer_l15_val=1` next cycle with `threadid=0`. Drive `ack` two cycles later. Expect `req0_ack` pulse and `cnt0=1`.
- Contention: both requesters valid continuously, `ack` returned immediately each time. Expect grants 0,1,0,1. With `L15_REQ_ARB_FIXED_PRIO_EN`: 0,0,0,0.
- Credit: requester 1 issues 4 requests with no responses. Expect the 5th is held (`val=0`) while requester 0 is still granted. One solicited response with `threadid=1` and `rdy1=1` frees a slot; grant follows.
- Broadcast: returntype 4'b0011, `rsp0_rdy=1`, `rsp1_rdy=0` for 3 cycles. Expect `rsp0_val` deasserts after cycle 1 and `req_ack=0`. Raise `rsp1_rdy`: `req_ack=1` in that cycle; counters unchanged.
- Orphan and reset: solicited response with `threadid=0` while `cnt0=0`. Expect `err_orphan=1` and `cnt0` stays 0. Assert `rst` in HDR. Expect all outputs 0 next cycle, FSM in IDLE, and no `req_ack` pulse.

Source files
------------

// File: rtl/l15_req_arb.sv
// Two-requester arbiter onto the single L1.5 request port; routes responses back by thread ID.
// Latency: grant registered (val one cycle after req_val); reqN_ack and response path are combinational.
// Backpressure: val/ack held to L1.5, per-requester credit of MAX_OUT; responses stall on owner rdy.
// Build option: L15_REQ_ARB_FIXED_PRIO_EN selects fixed requester-0 priority instead of round-robin.
module l15_req_arb #(
    parameter int REQ_W   = 113,
    parameter int MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_val,
    input  logic [REQ_W-1:0] req0_data,
    output logic             req0_ack,
    input  logic             req1_val,
    input  logic [REQ_W-1:0] req1_data,
    output logic             req1_ack,
    output logic             transducer_l15_val,
    output logic [REQ_W-1:0] transducer_l15_req,
    output logic             transducer_l15_threadid,
    input  logic             l15_transducer_header_ack,
    input  logic             l15_transducer_ack,
    input  logic             l15_transducer_val,
    input  logic [3:0]       l15_transducer_returntype,
    input  logic             l15_transducer_threadid,
    output logic             transducer_l15_req_ack,
    output logic             rsp0_val,
    input  logic             rsp0_rdy,
    output logic             rsp1_val,
    input  logic             rsp1_rdy,
    output logic             err_orphan
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HDR} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    state_t           state_q, state_d;
    logic [REQ_W-1:0] req_q, req_d;
    logic             tid_q, tid_d;
    logic [3:0]       cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             err_q, err_d;
`ifndef L15_REQ_ARB_FIXED_PRIO_EN
    logic             last_gnt_q, last_gnt_d;
`endif

    logic elig0, elig1, gnt, unsol, dec0, dec1;

    assign elig0 = req0_val && (cnt0_q < MAX_CNT);
    assign elig1 = req1_val && (cnt1_q < MAX_CNT);

    // Request sequencing
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        tid_d    = tid_q;
        req0_ack = 1'b0;
        req1_ack = 1'b0;
        gnt      = 1'b0;
`ifndef L15_REQ_ARB_FIXED_PRIO_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (elig0 || elig1) begin
`ifdef L15_REQ_ARB_FIXED_PRIO_EN
                    gnt = ~elig0;
`else
                    gnt        = (elig0 && elig1) ? ~last_gnt_q : elig1;
                    last_gnt_d = gnt;
`endif
                    req_d   = gnt ? req1_data : req0_data;
                    tid_d   = gnt;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_HDR: begin
                if (l15_transducer_ack) begin
                    req0_ack = ~tid_q;
                    req1_ack = tid_q;
                    state_d  = ST_IDLE;
                end else if (l15_transducer_header_ack) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign transducer_l15_val      = (state_q != ST_IDLE);
    assign transducer_l15_req      = req_q;
    assign transducer_l15_threadid = tid_q;
    assign err_orphan              = err_q;

    // Response routing: invalidations and interrupts go to both requesters
    assign unsol = (l15_transducer_returntype == 4'b0011) ||
                   (l15_transducer_returntype == 4'b0111);

    always_comb begin
        rsp0_val               = 1'b0;
        rsp1_val               = 1'b0;
        transducer_l15_req_ack = 1'b0;
        done0_d                = done0_q;
        done1_d                = done1_q;
        dec0                   = 1'b0;
        dec1                   = 1'b0;
        if (l15_transducer_val) begin
            if (unsol) begin
                rsp0_val               = ~done0_q;
                rsp1_val               = ~done1_q;
                transducer_l15_req_ack = (rsp0_rdy || done0_q) && (rsp1_rdy || done1_q);
                if (transducer_l15_req_ack) begin
                    done0_d = 1'b0;
                    done1_d = 1'b0;
                end else begin
                    if (rsp0_rdy) done0_d = 1'b1;
                    if (rsp1_rdy) done1_d = 1'b1;
                end
            end else if (l15_transducer_threadid) begin
                rsp1_val               = 1'b1;
                transducer_l15_req_ack = rsp1_rdy;
                dec1                   = rsp1_rdy;
            end else begin
                rsp0_val               = 1'b1;
                transducer_l15_req_ack = rsp0_rdy;
                dec0                   = rsp0_rdy;
            end
        end
    end

    // A same-cycle issue and retire cancel out; a retire at zero is an orphan
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        err_d  = err_q;
        if (req0_ack && !dec0) begin
            cnt0_d = cnt0_q + 4'd1;
        end else if (dec0 && !req0_ack) begin
            if (cnt0_q == 4'd0) err_d  = 1'b1;
            else                cnt0_d = cnt0_q - 4'd1;
        end
        if (req1_ack && !dec1) begin
            cnt1_d = cnt1_q + 4'd1;
        end else if (dec1 && !req1_ack) begin
            if (cnt1_q == 4'd0) err_d  = 1'b1;
            else                cnt1_d = cnt1_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            tid_q   <= 1'b0;
            cnt0_q  <= 4'd0;
            cnt1_q  <= 4'd0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
`ifndef L15_REQ_ARB_FIXED_PRIO_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            tid_q   <= tid_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
`ifndef L15_REQ_ARB_FIXED_PRIO_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end
endmodule
